ram_burst_master: RTL

//  Bus initiator for the 8-bit single-port program/data RAM (negedge write, negedge-registered read address).

---
 rtl/ram_burst_master_pkg.sv | 15 +
 rtl/ram_burst_master_ptr.sv | 50 +++++
 rtl/ram_burst_master.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/ram_burst_master_pkg.sv
// Shared definitions for the RAM burst master: default widths and FSM state type.
package ram_burst_master_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR      = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_RD_OUT  = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

endpackage

// File: rtl/ram_burst_master_ptr.sv
// Burst pointer/count register pair: load on command accept, step per byte.
// ptr wraps modulo 2^ADDR_W; last flags the final byte (remaining count zero).
module ram_burst_master_ptr
  import ram_burst_master_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] load_ptr,
  input  logic [ADDR_W-1:0] load_cnt,
  output logic [ADDR_W-1:0] ptr,
  output logic [ADDR_W-1:0] ptr_inc,
  output logic              last
);

  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  // Next pointer/count: load wins over step, otherwise hold.
  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (load) begin
      ptr_d = load_ptr;
      cnt_d = load_cnt;
    end else if (step) begin
      ptr_d = ptr_q + ADDR_W'(1);
      cnt_d = cnt_q - ADDR_W'(1);
    end
  end

  // Pointer/count registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  assign ptr     = ptr_q;
  assign ptr_inc = ptr_q + ADDR_W'(1);
  assign last    = (cnt_q == '0);

endmodule

// File: rtl/ram_burst_master.sv
// Burst initiator for the 8-bit single-port RAM (negedge write, negedge-latched
// read address). Write bursts take one byte per cycle from the wdata stream;
// read bursts return one byte per two cycles on the rdata stream.
// Optional feature macro CHECKSUM_EN: adds a running mod-2^DATA_W checksum
// output of all bytes moved in the current burst.
module ram_burst_master
  import ram_burst_master_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [ADDR_W-1:0] cmd_len,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  input  logic [DATA_W-1:0] wdata,
  output logic              rdata_valid,
  input  logic              rdata_ready,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] adrs,
  output logic [DATA_W-1:0] data,
  output logic              wr_en,
  input  logic [DATA_W-1:0] q
`ifdef CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] adrs_q, adrs_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              wr_en_q, wr_en_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rdata_valid_q, rdata_valid_d;

  logic              ptr_load;
  logic              ptr_step;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] ptr_inc;
  logic              ptr_last;

  ram_burst_master_ptr #(
    .ADDR_W(ADDR_W)
  ) u_ptr (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (ptr_load),
    .step    (ptr_step),
    .load_ptr(cmd_base),
    .load_cnt(cmd_len),
    .ptr     (ptr),
    .ptr_inc (ptr_inc),
    .last    (ptr_last)
  );

  // FSM next state and RAM-port/read-holding register updates.
  always_comb begin
    state_d       = state_q;
    adrs_d        = adrs_q;
    data_d        = data_q;
    wr_en_d       = 1'b0;
    rdata_d       = rdata_q;
    rdata_valid_d = rdata_valid_q;
    ptr_load      = 1'b0;
    ptr_step      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          ptr_load = 1'b1;
          if (cmd_write) begin
            state_d = ST_WR;
          end else begin
            adrs_d  = cmd_base;
            state_d = ST_RD_WAIT;
          end
        end
      end
      ST_WR: begin
        if (wdata_valid) begin
          adrs_d   = ptr;
          data_d   = wdata;
          wr_en_d  = 1'b1;
          ptr_step = 1'b1;
          if (ptr_last) state_d = ST_DONE;
        end
      end
      ST_RD_WAIT: begin
        // RAM latched adrs at the intervening negedge, so q is valid now.
        rdata_d       = q;
        rdata_valid_d = 1'b1;
        state_d       = ST_RD_OUT;
      end
      ST_RD_OUT: begin
        if (rdata_ready) begin
          rdata_valid_d = 1'b0;
          if (ptr_last) begin
            state_d = ST_DONE;
          end else begin
            ptr_step = 1'b1;
            adrs_d   = ptr_inc;
            state_d  = ST_RD_WAIT;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and RAM-port registers; reset abandons any burst in flight.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      adrs_q        <= '0;
      data_q        <= '0;
      wr_en_q       <= 1'b0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      adrs_q        <= adrs_d;
      data_q        <= data_d;
      wr_en_q       <= wr_en_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
    end
  end

  assign cmd_ready   = (state_q == ST_IDLE);
  assign wdata_ready = (state_q == ST_WR);
  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);
  assign adrs        = adrs_q;
  assign data        = data_q;
  assign wr_en       = wr_en_q;
  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;

`ifdef CHECKSUM_EN
  logic [DATA_W-1:0] checksum_q, checksum_d;

  function automatic logic [DATA_W-1:0] csum_add(input logic [DATA_W-1:0] acc,
                                                 input logic [DATA_W-1:0] b);
    return acc + b;
  endfunction

  // Checksum: cleared on accept, accumulates every byte handshake.
  always_comb begin
    checksum_d = checksum_q;
    if (state_q == ST_IDLE && cmd_valid) begin
      checksum_d = '0;
    end else if (state_q == ST_WR && wdata_valid) begin
      checksum_d = csum_add(checksum_q, wdata);
    end else if (state_q == ST_RD_OUT && rdata_ready) begin
      checksum_d = csum_add(checksum_q, rdata_q);
    end
  end

  // Checksum register.
  always_ff @(posedge clock) begin
    if (!reset_n) checksum_q <= '0;
    else          checksum_q <= checksum_d;
  end

  assign checksum = checksum_q;
`endif

endmodule
